// File: rtl/cnn_frame_feeder.sv
`default_nettype none
// ============================================================================
// Module   : cnn_frame_feeder
// Purpose  : Buffers one raster-order IMG_W x IMG_H 8-bit frame received over
//            a valid/ready handshake. Once CNN_TOP is idle it issues a
//            one-cycle start pulse and replays the frame as a gap-free
//            pixel_valid burst. It then waits for the CNN result, with a
//            timeout.
// Ports    : clk, rst          - clock and asynchronous active-high reset
//            in_valid/in_pixel - upstream pixel stream; in_ready = accept
//            cnn_busy          - CNN_TOP busy; a start is held off while high
//            cnn_result_valid  - CNN_TOP result pulse, honoured only while
//                                waiting for a result
//            start_signal      - one-cycle start pulse to CNN_TOP
//            pixel_valid/pixel_in - replayed burst to CNN_TOP
//            soft_clear        - discard the frame and return to filling
//            frame_done        - one-cycle pulse when a result is received
//            timeout_err       - sticky flag, set when a result never arrives
//            frames_sent       - count of fully streamed frames (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module cnn_frame_feeder #(
  parameter int IMG_W          = 32,
  parameter int IMG_H          = 32,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_pixel,
  output logic             in_ready,
  input  logic             cnn_busy,
  input  logic             cnn_result_valid,
  output logic             start_signal,
  output logic             pixel_valid,
  output logic [7:0]       pixel_in,
  input  logic             soft_clear,
  output logic             frame_done,
  output logic             timeout_err,
  output logic [CNT_W-1:0] frames_sent
);

  localparam int N  = IMG_W * IMG_H;
  localparam int AW = $clog2(N) + 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  // The wait timer runs 0..TIMEOUT_CYCLES-1.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [AW-1:0] c_LAST_IDX = AW'(N - 1);
  localparam logic [AW-1:0] c_N        = AW'(N);
  localparam logic [TW-1:0] c_TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_FILL   = 3'd0;
  localparam logic [2:0] S_ARM    = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;

  logic [2:0]       state_q,    state_d;
  logic [AW-1:0]    wptr_q,     wptr_d;
  logic [AW-1:0]    rptr_q,     rptr_d;
  logic [TW-1:0]    timer_q,    timer_d;
  logic             in_ready_q, in_ready_d;
  logic             start_q,    start_d;
  logic             pvalid_q,   pvalid_d;
  logic [7:0]       pixel_q,    pixel_d;
  logic             done_q,     done_d;
  logic             timeout_q,  timeout_d;
  logic [CNT_W-1:0] frames_q,   frames_d;

  logic             w_wr_en;
  logic [IW-1:0]    w_rd_idx;
  logic [7:0]       w_rd_data;

  // Frame store: contents are never reset, only the pointers are.
  logic [7:0] mem [N];

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      mem[wptr_q[IW-1:0]] <= in_pixel;
    end
  end

  // In START the read of pixel 0 is issued so it lands on the first burst
  // cycle; in STREAM rptr_q already points at the next pixel to present.
  assign w_rd_idx  = (state_q == S_START) ? '0 : rptr_q[IW-1:0];
  assign w_rd_data = mem[w_rd_idx];

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    timer_d   = timer_q;
    start_d   = 1'b0;
    pvalid_d  = 1'b0;
    pixel_d   = 8'h00;
    done_d    = 1'b0;
    timeout_d = timeout_q;
    frames_d  = frames_q;
    w_wr_en   = 1'b0;

    if (soft_clear) begin
      // Abort overrides every simultaneous event, including a final accept,
      // a result and a timeout.
      state_d = S_FILL;
      wptr_d  = '0;
    end else begin
      case (state_q)
        S_FILL: begin
          if (in_valid && in_ready_q) begin
            w_wr_en = 1'b1;
            wptr_d  = wptr_q + AW'(1);
            if (wptr_q == c_LAST_IDX) begin
              state_d = S_ARM;
            end
          end
        end
        S_ARM: begin
          if (!cnn_busy) begin
            state_d = S_START;
            start_d = 1'b1;
          end
        end
        S_START: begin
          state_d  = S_STREAM;
          pvalid_d = 1'b1;
          pixel_d  = w_rd_data;
          rptr_d   = AW'(1);
        end
        S_STREAM: begin
          if (rptr_q != c_N) begin
            pvalid_d = 1'b1;
            pixel_d  = w_rd_data;
            rptr_d   = rptr_q + AW'(1);
          end else begin
            // Last pixel is on the bus now; the burst ends next cycle.
            state_d  = S_WAIT;
            timer_d  = '0;
            frames_d = frames_q + CNT_W'(1);
          end
        end
        S_WAIT: begin
          // A result on the threshold cycle still wins over the timeout.
          if (cnn_result_valid) begin
            done_d  = 1'b1;
            wptr_d  = '0;
            state_d = S_FILL;
          end else if (timer_q == c_TO_LAST) begin
            timeout_d = 1'b1;
            wptr_d    = '0;
            state_d   = S_FILL;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: begin
          state_d = S_FILL;
          wptr_d  = '0;
        end
      endcase
    end

    in_ready_d = (state_d == S_FILL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FILL;
      wptr_q     <= '0;
      rptr_q     <= '0;
      timer_q    <= '0;
      in_ready_q <= 1'b0;
      start_q    <= 1'b0;
      pvalid_q   <= 1'b0;
      pixel_q    <= 8'h00;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      frames_q   <= '0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      timer_q    <= timer_d;
      in_ready_q <= in_ready_d;
      start_q    <= start_d;
      pvalid_q   <= pvalid_d;
      pixel_q    <= pixel_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      frames_q   <= frames_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign start_signal = start_q;
  assign pixel_valid  = pvalid_q;
  assign pixel_in     = pixel_q;
  assign frame_done   = done_q;
  assign timeout_err  = timeout_q;
  assign frames_sent  = frames_q;

endmodule
`default_nettype wire

// File: tb/tb_cnn_frame_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnn_frame_feeder
// Purpose  : Self-checking bench for cnn_frame_feeder. A behavioural model
//            (frame queue plus burst/wait counters) predicts every output each
//            cycle; literal expectations pin the model at key points.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cnn_frame_feeder;

  localparam int IMG_W = 32;
  localparam int IMG_H = 32;
  localparam int N     = IMG_W * IMG_H;
  localparam int TO    = 50;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, cnn_busy, cnn_result_valid, soft_clear;
  logic [7:0]       in_pixel;
  logic             in_ready, start_signal, pixel_valid, frame_done, timeout_err;
  logic [7:0]       pixel_in;
  logic [CNT_W-1:0] frames_sent;

  cnn_frame_feeder #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pixel(in_pixel),
    .in_ready(in_ready), .cnn_busy(cnn_busy),
    .cnn_result_valid(cnn_result_valid), .start_signal(start_signal),
    .pixel_valid(pixel_valid), .pixel_in(pixel_in), .soft_clear(soft_clear),
    .frame_done(frame_done), .timeout_err(timeout_err),
    .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_FILL = 0, M_ARM = 1, M_START = 2, M_STREAM = 3, M_WAIT = 4;
  int               m_mode, m_k, m_w;
  logic [7:0]       m_q[$];
  logic             m_acc;
  logic             e_rdy, e_st, e_pv, e_done, e_to;
  logic [7:0]       e_pix;
  logic [CNT_W-1:0] e_fr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = M_FILL; m_q.delete(); m_k = 0; m_w = 0;
      e_rdy = 0; e_st = 0; e_pv = 0; e_pix = 0; e_done = 0; e_to = 0; e_fr = '0;
    end else begin
      m_acc  = in_valid && e_rdy;
      e_st   = 0;
      e_pv   = 0;
      e_done = 0;
      if (soft_clear) begin
        m_mode = M_FILL; m_q.delete();
      end else begin
        case (m_mode)
          M_FILL: if (m_acc) begin
            m_q.push_back(in_pixel);
            if (m_q.size() == N) m_mode = M_ARM;
          end
          M_ARM: if (!cnn_busy) begin m_mode = M_START; e_st = 1; end
          M_START: begin m_mode = M_STREAM; m_k = 0; e_pv = 1; e_pix = m_q[0]; end
          M_STREAM: begin
            m_k++;
            if (m_k < N) begin e_pv = 1; e_pix = m_q[m_k]; end
            else begin e_fr++; m_mode = M_WAIT; m_w = 0; end
          end
          M_WAIT: begin
            if (cnn_result_valid) begin
              e_done = 1; m_q.delete(); m_mode = M_FILL;
            end else begin
              m_w++;
              if (m_w == TO) begin e_to = 1; m_q.delete(); m_mode = M_FILL; end
            end
          end
          default: m_mode = M_FILL;
        endcase
      end
      e_rdy = (m_mode == M_FILL);
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    check("in_ready", in_ready, e_rdy);
    check("start_signal", start_signal, e_st);
    check("pixel_valid", pixel_valid, e_pv);
    if (e_pv) check("pixel_in", pixel_in, e_pix);
    check("frame_done", frame_done, e_done);
    check("timeout_err", timeout_err, e_to);
    check("frames_sent", frames_sent, e_fr);
  end

  // ---------------- observation counters ----------------
  int         st_cnt = 0, st_cyc = 0, fall_cnt = 0, fall_cyc = 0;
  int         pv_k = 0, done_cnt = 0, to_cyc = -1;
  logic       pv_prev = 0, to_prev = 0;
  logic [7:0] cap [N];

  always @(negedge clk) begin
    if (start_signal) begin st_cnt++; st_cyc = cyc; pv_k = 0; end
    if (pixel_valid) begin
      if (pv_k < N) cap[pv_k] = pixel_in;
      pv_k++;
    end
    if (pv_prev && !pixel_valid) begin fall_cnt++; fall_cyc = cyc; end
    if (frame_done) done_cnt++;
    if (timeout_err && !to_prev) to_cyc = cyc;
    pv_prev = pixel_valid;
    to_prev = timeout_err;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic drive_frame(input int kind, input int duty);
    int i = 0;
    int guard = 0;
    logic acc;
    while (i < N && guard < 20 * N) begin
      in_valid = (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
      in_pixel = (kind == 0) ? 8'(100 + ((i % IMG_W) ^ (i / IMG_W))) : 8'($urandom);
      acc = in_valid && in_ready;
      tick();
      if (acc) i++;
      guard++;
    end
    in_valid = 0;
    check("fill_complete", i, N);
  endtask

  task automatic wait_start(output int t);
    int base = st_cnt;
    int g = 0;
    while (st_cnt == base && g < 3000) begin tick(); g++; end
    check("start_seen", 32'(st_cnt - base), 1);
    t = st_cyc;
  endtask

  task automatic wait_fall(output int e);
    int base = fall_cnt;
    int g = 0;
    while (fall_cnt == base && g < 3000) begin tick(); g++; end
    check("burst_end_seen", 32'(fall_cnt - base), 1);
    e = fall_cyc;
  endtask

  task automatic pulse_result();
    cnn_result_valid = 1; tick(); cnn_result_valid = 0;
  endtask

  // ---------------- main sequence ----------------
  int T, E, c, dbase, r;

  initial begin
    rst = 1; in_valid = 0; in_pixel = 0; cnn_busy = 0;
    cnn_result_valid = 0; soft_clear = 0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_start", start_signal, 0);
    check("rst_pixel_valid", pixel_valid, 0);
    check("rst_pixel_in", pixel_in, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_frames", frames_sent, 0);
    rst = 0;

    // Frame 1: pattern 100+(x^y), CNN idle
    drive_frame(0, 100);
    wait_start(T);
    wait_fall(E);
    check("f1_burst_len", pv_k, N);
    check("f1_fall_offset", 32'(E - T), N + 1);
    check("f1_frames", frames_sent, 1);
    check("f1_pix0", cap[0], 100);
    check("f1_pix37", cap[37], 104);
    check("f1_pix65", cap[65], 103);
    check("f1_pix1023", cap[1023], 100);
    // Result 30 cycles after burst end
    dbase = done_cnt;
    wait_until(E + 30);
    pulse_result();
    check("f1_done_pulse", frame_done, 1);
    check("f1_ready_after_done", in_ready, 1);
    tick();
    check("f1_done_width", 32'(done_cnt - dbase), 1);

    // Frame 2: random data, 50% gaps, CNN busy for 500 cycles afterwards
    cnn_busy = 1;
    drive_frame(1, 50);
    in_valid = 1; in_pixel = 8'hEE;
    r = st_cnt;
    repeat (500) tick();
    check("busy_no_extra_accept", in_ready, 0);
    check("busy_no_start", 32'(st_cnt - r), 0);
    c = cyc;
    cnn_busy = 0; in_valid = 0;
    wait_start(T);
    check("start_after_busy", 32'(T - c), 1);
    wait_fall(E);
    check("f2_burst_len", pv_k, N);
    check("f2_frames", frames_sent, 2);
    // Result exactly on the timeout-threshold cycle: result wins
    wait_until(E + TO - 1);
    pulse_result();
    check("thresh_done", frame_done, 1);
    check("thresh_no_timeout", timeout_err, 0);

    // Frame 3: no result -> timeout
    drive_frame(0, 100);
    wait_start(T);
    wait_fall(E);
    dbase = done_cnt;
    wait_until(E + TO + 1);
    check("timeout_latency", 32'(to_cyc - E), TO);
    check("timeout_set", timeout_err, 1);
    check("timeout_ready", in_ready, 1);
    check("timeout_no_done", 32'(done_cnt - dbase), 0);
    // Frame 4 still streams, timeout stays sticky
    drive_frame(1, 100);
    wait_start(T);
    wait_fall(E);
    check("f4_frames", frames_sent, 4);
    check("f4_timeout_sticky", timeout_err, 1);
    wait_until(E + 5);
    pulse_result();

    // Frame 5: soft_clear at burst pixel 400
    drive_frame(1, 100);
    wait_start(T);
    wait_until(T + 1 + 400);
    soft_clear = 1; tick(); soft_clear = 0;
    check("sc_pv_low", pixel_valid, 0);
    check("sc_pixels_seen", pv_k, 401);
    check("sc_frames_kept", frames_sent, 4);
    check("sc_ready", in_ready, 1);
    // Frame 6 refills from pointer 0; result coincident with soft_clear
    drive_frame(1, 50);
    wait_start(T);
    wait_fall(E);
    check("f6_burst_len", pv_k, N);
    check("f6_frames", frames_sent, 5);
    wait_until(E + 3);
    soft_clear = 1; cnn_result_valid = 1; tick();
    soft_clear = 0; cnn_result_valid = 0;
    check("sc_beats_result", frame_done, 0);
    check("sc_result_ready", in_ready, 1);

    // Frame 7: async reset mid-burst
    drive_frame(1, 50);
    wait_start(T);
    r = $urandom_range(5, 1000);
    wait_until(T + r);
    @(posedge clk); #3;
    rst = 1; #1;
    check("arst_pixel_valid", pixel_valid, 0);
    check("arst_start", start_signal, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_pixel_in", pixel_in, 0);
    check("arst_timeout", timeout_err, 0);
    check("arst_frames", frames_sent, 0);
    @(posedge clk); @(posedge clk); #2;
    rst = 0;
    // Frame 8 after reset: every pixel checked by the model
    drive_frame(1, 50);
    wait_start(T);
    wait_fall(E);
    check("f8_burst_len", pv_k, N);
    check("f8_frames", frames_sent, 1);
    wait_until(E + 2);
    pulse_result();
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
